// File: rtl/weight_fetch_ctrl.sv
// Weight-bank read sequencer: sweeps a shared address over DEPTH words for n_pass passes and tags returned data.
// Latency: first rd_en one cycle after start; rdata tags follow rd_en by RD_LAT; finish RD_LAT+1 cycles after last issue.
// Backpressure: stall suppresses address issue in FETCH only; tag pipeline never stalls. Optional macro WEIGHT_FETCH_CTRL_STALL_CNT_EN adds stall_cycles.
module weight_fetch_ctrl #(
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16,
  parameter int RD_LAT = 1,
  parameter int PASS_W = 4
) (
  input  logic              clk,
  input  logic              xrst,
  input  logic              start,
  input  logic [PASS_W-1:0] n_pass,
  input  logic              stall,
  output logic [ADDR_W-1:0] raddr,
  output logic              rd_en,
  output logic              rdata_valid,
  output logic              acc_clr,
  output logic              acc_last,
  output logic [PASS_W-1:0] pass_idx,
  output logic              busy,
  output logic              finish
`ifdef WEIGHT_FETCH_CTRL_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cycles
`endif
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] addr;
  logic [PASS_W-1:0] pass;
  logic [PASS_W-1:0] npass_q;
  logic [2:0]        lat_cnt;
  logic              last_addr;
  logic              last_pass;
  logic              issue;
  logic              accept;
  logic [2:0]        tag_pipe [RD_LAT];

  assign last_addr = (addr == ADDR_W'(DEPTH - 1));
  assign last_pass = (pass == (npass_q - PASS_W'(1)));
  assign issue     = (state == FETCH) && !stall;
  assign accept    = (state == IDLE) && start;

  assign raddr    = addr;
  assign pass_idx = pass;
  assign {rdata_valid, acc_clr, acc_last} = tag_pipe[RD_LAT-1];

  // Next-state and control outputs; DRAIN holds for exactly RD_LAT cycles.
  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    busy      = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = FETCH;
      end
      FETCH: begin
        busy  = 1'b1;
        rd_en = !stall;
        if (issue && last_addr && last_pass) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (lat_cnt == 3'(RD_LAT - 1)) state_nxt = DONE;
      end
      DONE: begin
        finish    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (xrst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Address/pass counters; both return to 0 after the final issue so they never exceed their limits.
  always_ff @(posedge clk) begin
    if (xrst) begin
      addr    <= '0;
      pass    <= '0;
      npass_q <= '0;
      lat_cnt <= '0;
    end else begin
      if (accept) begin
        addr    <= '0;
        pass    <= '0;
        npass_q <= (n_pass == '0) ? PASS_W'(1) : n_pass;
      end
      if (issue) begin
        if (last_addr) begin
          addr <= '0;
          pass <= last_pass ? '0 : pass + PASS_W'(1);
        end else begin
          addr <= addr + ADDR_W'(1);
        end
      end
      lat_cnt <= (state == DRAIN) ? lat_cnt + 3'd1 : 3'd0;
    end
  end

  // Tag pipeline {valid, first, last} delayed RD_LAT cycles to line up with bank rdata.
  always_ff @(posedge clk) begin
    if (xrst) begin
      for (int i = 0; i < RD_LAT; i++) tag_pipe[i] <= 3'b000;
    end else begin
      tag_pipe[0] <= {issue, issue && (addr == '0), issue && last_addr};
      for (int i = 1; i < RD_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

`ifdef WEIGHT_FETCH_CTRL_STALL_CNT_EN
  // Stalled FETCH cycles, saturating; value survives finish until the next accepted start.
  always_ff @(posedge clk) begin
    if (xrst || accept)                                 stall_cycles <= '0;
    else if (state == FETCH && stall && stall_cycles != 16'hFFFF) stall_cycles <= stall_cycles + 16'd1;
  end
`endif

endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// Bench for weight_fetch_ctrl: directed and randomized runs on RD_LAT=1 and RD_LAT=3 instances.
// Reference model: per-run issue index k, with addr=k%16, pass=k/16, tag due RD_LAT cycles after issue.
// Outputs are sampled on the falling edge; inputs driven 1 time unit after the rising edge.
module tb_weight_fetch_ctrl;

  logic       clk;
  logic       xrst;
  logic       start;
  logic [3:0] n_pass;
  logic       stall;
  logic       sel;
  int         checks;
  int         errors;

  logic [3:0] raddr1, raddr3, pidx1, pidx3;
  logic rd1, rd3, v1, v3, clr1, clr3, last1, last3, busy1, busy3, fin1, fin3;
`ifdef WEIGHT_FETCH_CTRL_STALL_CNT_EN
  logic [15:0] sc1, sc3;
`endif

  weight_fetch_ctrl #(.ADDR_W(4), .DEPTH(16), .RD_LAT(1), .PASS_W(4)) dut (
    .clk(clk), .xrst(xrst), .start(start & ~sel), .n_pass(n_pass), .stall(stall),
    .raddr(raddr1), .rd_en(rd1), .rdata_valid(v1), .acc_clr(clr1), .acc_last(last1),
    .pass_idx(pidx1), .busy(busy1), .finish(fin1)
`ifdef WEIGHT_FETCH_CTRL_STALL_CNT_EN
    , .stall_cycles(sc1)
`endif
  );

  weight_fetch_ctrl #(.ADDR_W(4), .DEPTH(16), .RD_LAT(3), .PASS_W(4)) dut3 (
    .clk(clk), .xrst(xrst), .start(start & sel), .n_pass(n_pass), .stall(stall),
    .raddr(raddr3), .rd_en(rd3), .rdata_valid(v3), .acc_clr(clr3), .acc_last(last3),
    .pass_idx(pidx3), .busy(busy3), .finish(fin3)
`ifdef WEIGHT_FETCH_CTRL_STALL_CNT_EN
    , .stall_cycles(sc3)
`endif
  );

  logic [3:0] o_raddr, o_pidx;
  logic o_rd, o_v, o_clr, o_last, o_busy, o_fin;
  assign o_raddr = sel ? raddr3 : raddr1;
  assign o_pidx  = sel ? pidx3  : pidx1;
  assign o_rd    = sel ? rd3    : rd1;
  assign o_v     = sel ? v3     : v1;
  assign o_clr   = sel ? clr3   : clr1;
  assign o_last  = sel ? last3  : last1;
  assign o_busy  = sel ? busy3  : busy1;
  assign o_fin   = sel ? fin3   : fin1;
`ifdef WEIGHT_FETCH_CTRL_STALL_CNT_EN
  logic [15:0] o_sc;
  assign o_sc = sel ? sc3 : sc1;
`endif

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_raddr"}, 32'(o_raddr), 0);
    check({tag, "_rd_en"}, 32'(o_rd), 0);
    check({tag, "_valid"}, 32'(o_v), 0);
    check({tag, "_clr"}, 32'(o_clr), 0);
    check({tag, "_last"}, 32'(o_last), 0);
    check({tag, "_pass"}, 32'(o_pidx), 0);
    check({tag, "_busy"}, 32'(o_busy), 0);
    check({tag, "_finish"}, 32'(o_fin), 0);
  endtask

  // One run: np passes; smode 0 none, 1 stall 3 cycles at addr 5 and 9, 2 random;
  // mid_start pulses start mid-FETCH and in DONE; abort_k >= 0 resets when issue index reaches it.
  task automatic run(input int np, input int smode, input int mid_start, input int abort_k);
    int  eff, total, k, c, drain, lat, held, nst, nvalid, nclr, nlast, w;
    int  due[$];
    int  wk[$];
    bit  done, fetching, st, at_pt;
    lat = sel ? 3 : 1;
    eff = (np == 0) ? 1 : np;
    total = eff * 16;
    k = 0; c = 0; drain = 0; held = 0; nst = 0; nvalid = 0; nclr = 0; nlast = 0; done = 0;
    @(posedge clk); #1;
    start = 1'b1;
    n_pass = 4'(np);
    stall = 1'($urandom_range(0, 1));
    @(negedge clk);
    check("idle_busy", 32'(o_busy), 0);
    check("idle_rd_en", 32'(o_rd), 0);
    while (!done && c < 3000) begin
      @(posedge clk); #1;
      c++;
      start = 1'b0;
      n_pass = 4'($urandom_range(0, 15));
      fetching = (k < total);
      if (abort_k >= 0 && k == abort_k && fetching) begin
        stall = 1'b0;
        xrst = 1'b1;
        @(negedge clk);
        check("abort_raddr", 32'(o_raddr), 32'(k % 16));
        check("abort_pass", 32'(o_pidx), 32'(k / 16));
        @(posedge clk); #1;
        xrst = 1'b0;
        @(negedge clk);
        check_zero("after_abort");
`ifdef WEIGHT_FETCH_CTRL_STALL_CNT_EN
        check("after_abort_stall_cycles", 32'(o_sc), 0);
`endif
        return;
      end
      if (!fetching) st = 1'($urandom_range(0, 1));
      else if (smode == 1) begin
        at_pt = (k == 5 || k == 9);
        st = at_pt && held < 3;
      end else if (smode == 2) st = ($urandom_range(0, 3) == 0);
      else st = 1'b0;
      stall = st;
      if (mid_start != 0 && c == 5) start = 1'b1;
      if (mid_start != 0 && !fetching && drain == lat) start = 1'b1;
      @(negedge clk);
      if (fetching) begin
        check("f_rd_en", 32'(o_rd), 32'(!st));
        check("f_raddr", 32'(o_raddr), 32'(k % 16));
        check("f_pass", 32'(o_pidx), 32'(k / 16));
        check("f_busy", 32'(o_busy), 1);
        check("f_finish", 32'(o_fin), 0);
        if (!st) begin
          due.push_back(c + lat);
          wk.push_back(k);
          k++;
          held = 0;
        end else begin
          nst++;
          held++;
        end
      end else if (drain < lat) begin
        check("d_busy", 32'(o_busy), 1);
        check("d_rd_en", 32'(o_rd), 0);
        check("d_finish", 32'(o_fin), 0);
        drain++;
      end else begin
        check("done_finish", 32'(o_fin), 1);
        check("done_busy", 32'(o_busy), 0);
        check("done_rd_en", 32'(o_rd), 0);
        done = 1'b1;
      end
      if (o_v) nvalid++;
      if (o_v && o_clr) nclr++;
      if (o_v && o_last) nlast++;
      if (due.size() > 0 && due[0] == c) begin
        void'(due.pop_front());
        w = wk.pop_front();
        check("valid", 32'(o_v), 1);
        check("acc_clr", 32'(o_clr), 32'(w % 16 == 0));
        check("acc_last", 32'(o_last), 32'(w % 16 == 15));
      end else begin
        check("no_valid", 32'(o_v), 0);
        check("no_clr", 32'(o_clr), 0);
        check("no_last", 32'(o_last), 0);
      end
    end
    check("run_completed", 32'(done), 1);
    check("valid_count", 32'(nvalid), 32'(total));
    check("clr_count", 32'(nclr), 32'(eff));
    check("last_count", 32'(nlast), 32'(eff));
`ifdef WEIGHT_FETCH_CTRL_STALL_CNT_EN
    check("stall_cycles", 32'(o_sc), 32'(nst));
    if (smode == 1) check("stall_cycles_directed", 32'(o_sc), 6);
`endif
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clk = 1'b0;
    xrst = 1'b1;
    start = 1'b0;
    stall = 1'b0;
    n_pass = 4'd0;
    sel = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    xrst = 1'b0;

    run(1, 0, 0, -1);
    run(0, 0, 0, -1);
    run(3, 0, 0, -1);
    run(1, 1, 0, -1);
    run(2, 0, 1, -1);
    run(1, 0, 0, -1);
    run(3, 0, 0, 23);
    repeat (5) begin
      @(posedge clk); #1;
      stall = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("post_abort_finish", 32'(o_fin), 0);
      check("post_abort_busy", 32'(o_busy), 0);
    end
    run(1, 0, 0, -1);
    for (int i = 0; i < 4; i++) run($urandom_range(0, 4), 2, $urandom_range(0, 1), -1);

    sel = 1'b1;
    run(1, 0, 0, -1);
    run(2, 2, 1, -1);
    run(1, 1, 0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
